// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed 7-segment display path.
package display_pkg;

    typedef logic [3:0] bcd_digit_t;

    // The downstream decoder drives all segments dark for this code.
    localparam bcd_digit_t BLANK_CODE = 4'hF;

    localparam int DEFAULT_NUM_DIGITS = 4;
    localparam int DEFAULT_SCAN_DIV   = 50000;

endpackage

// File: rtl/display_scanner_prescaler.sv
// Terminal-count divider: tick is high during the last cycle of each DIV-cycle period.
module scan_prescaler
    import display_pkg::*;
#(
    parameter int DIV = DEFAULT_SCAN_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    // With DIV == 1 the counter never leaves 0, so tick is constantly high.
    assign tick = (count == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Scans a double-buffered BCD value across NUM_DIGITS common-cathode digits,
// one digit per prescaler tick, with optional leading-zero blanking.
module display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS    = DEFAULT_NUM_DIGITS,
    parameter int SCAN_DIV      = DEFAULT_SCAN_DIV,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic [3:0]              digit_data,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    logic          tick;
    logic          wrap;
    logic          commit;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_next;
    logic [VW-1:0] shadow;
    logic [VW-1:0] display;
    logic [VW-1:0] display_next;
    logic          pending;

    scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Walk from the most significant digit down; a digit is blanked only while
    // it and everything above it are zero. Digit 0 always shows.
    function automatic bcd_digit_t digit_code(input logic [VW-1:0] disp,
                                              input logic [IW-1:0] sel);
        bcd_digit_t code;
        logic       zero_run;
        code     = disp[3:0];
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (disp[4*i +: 4] != 4'h0) zero_run = 1'b0;
            if (IW'(i) == sel) begin
                code = (BLANK_LEADING && (i > 0) && zero_run) ? BLANK_CODE : disp[4*i +: 4];
            end
        end
        return code;
    endfunction

    // load is a fire-and-forget strobe: it is never back-pressured, and a later
    // load before the frame boundary simply replaces the shadow contents.
    always_comb begin
        wrap         = tick && (idx == IW'(NUM_DIGITS - 1));
        commit       = wrap && pending;
        display_next = commit ? shadow : display;
        idx_next     = idx;
        if (wrap) begin
            idx_next = '0;
        end else if (tick) begin
            idx_next = idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            shadow     <= '0;
            display    <= '0;
            pending    <= 1'b0;
            digit_en   <= NUM_DIGITS'(1);
            digit_data <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            idx        <= idx_next;
            display    <= display_next;
            frame_done <= wrap;
            if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            // Outputs use the post-commit contents so a new frame starts clean.
            if (tick) begin
                digit_en   <= NUM_DIGITS'(1) << idx_next;
                digit_data <= digit_code(display_next, idx_next);
            end
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: three configurations driven by shared stimulus and
// checked every cycle against a time-based model of frames and digit slots.
module tb_display_scanner;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;

    logic [3:0] data_o [3];
    logic [3:0] en_o   [3];
    logic       fd_o   [3];

    int div_cfg   [3] = '{4, 4, 1};
    bit blank_cfg [3] = '{1'b1, 1'b0, 1'b1};

    // Model state: k = clock edges since reset release, plus shown/pending values.
    int          k        [3];
    logic [15:0] shown    [3];
    logic [15:0] pend_val [3];
    bit          pend     [3];

    int checks;
    int errors;

    display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut_blank (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .digit_data(data_o[0]), .digit_en(en_o[0]), .frame_done(fd_o[0])
    );

    display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_LEADING(1'b0)) dut_plain (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .digit_data(data_o[1]), .digit_en(en_o[1]), .frame_done(fd_o[1])
    );

    display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(1), .BLANK_LEADING(1'b1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .digit_data(data_o[2]), .digit_en(en_o[2]), .frame_done(fd_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frames are DIV*4 edges long; a value loaded before a frame boundary is
    // shown from that boundary on, a load on the boundary waits one more frame.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                k[i]        <= 0;
                shown[i]    <= '0;
                pend[i]     <= 1'b0;
                pend_val[i] <= '0;
            end else begin
                if (pend[i] && (((k[i] + 1) % (div_cfg[i] * 4)) == 0)) begin
                    shown[i] <= pend_val[i];
                    pend[i]  <= 1'b0;
                end
                if (load) begin
                    pend_val[i] <= value;
                    pend[i]     <= 1'b1;
                end
                k[i] <= k[i] + 1;
            end
        end
    end

    function automatic logic [3:0] exp_code(logic [15:0] v, int pos, bit blank);
        int sig = 1;
        for (int d = 0; d < 4; d++) begin
            if (v[4*d +: 4] != 4'h0) sig = d + 1;
        end
        if (blank && pos >= sig) return 4'hF;
        return v[4*pos +: 4];
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            int         pos;
            logic [3:0] exp_en;
            logic [3:0] exp_data;
            logic       exp_fd;
            pos      = (k[i] / div_cfg[i]) % 4;
            exp_en   = 4'b0001 << pos;
            exp_data = exp_code(shown[i], pos, blank_cfg[i]);
            exp_fd   = (k[i] > 0) && ((k[i] % (div_cfg[i] * 4)) == 0);
            checks++;
            assert (en_o[i] === exp_en) else begin
                errors++;
                $error("FAIL digit_en[%0d] k=%0d got %b expected %b", i, k[i], en_o[i], exp_en);
            end
            checks++;
            assert (data_o[i] === exp_data) else begin
                errors++;
                $error("FAIL digit_data[%0d] k=%0d got %h expected %h", i, k[i], data_o[i], exp_data);
            end
            checks++;
            assert (fd_o[i] === exp_fd) else begin
                errors++;
                $error("FAIL frame_done[%0d] k=%0d got %b expected %b", i, k[i], fd_o[i], exp_fd);
            end
        end
    endtask

    // Called at a falling edge: check outputs, drive inputs for the next rising edge.
    task automatic step(bit ld, logic [15:0] v);
        check_all();
        load  = ld;
        value = v;
        @(negedge clk);
    endtask

    task automatic run(int n);
        repeat (n) step(1'b0, value);
    endtask

    // Idle until the next driven load lands on an edge at the given frame phase.
    task automatic wait_phase(int ph);
        int n = 0;
        while ((((k[0] + 1) % 16) != ph) && (n < 64)) begin
            step(1'b0, value);
            n++;
        end
        checks++;
        assert (n < 64) else begin
            errors++;
            $error("FAIL wait_phase timeout got %0d cycles expected < 64", n);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        load   = 1'b0;
        value  = '0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        run(3);
        rst_n = 1'b1;
        run(20);

        // Mid-frame load must not disturb the frame in progress.
        wait_phase(6);
        step(1'b1, 16'h1234);
        run(40);

        step(1'b1, 16'h0050);
        run(36);

        // Two loads in one frame: only the later one is ever displayed.
        wait_phase(2);
        step(1'b1, 16'h1111);
        step(1'b0, 16'h1111);
        step(1'b1, 16'h2222);
        run(36);

        // Load on the commit edge: the older shadow value is committed first.
        wait_phase(8);
        step(1'b1, 16'h4321);
        wait_phase(0);
        step(1'b1, 16'h5678);
        run(40);

        step(1'b1, 16'h00A0);
        run(36);

        // Asynchronous reset while digit 2 is lit.
        begin
            int n = 0;
            while ((((k[0] / 4) % 4) != 2) && (n < 64)) begin
                step(1'b0, value);
                n++;
            end
            checks++;
            assert (n < 64) else begin
                errors++;
                $error("FAIL wait_digit2 timeout got %0d cycles expected < 64", n);
            end
        end
        check_all();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            assert (en_o[i] === 4'b0001) else begin
                errors++;
                $error("FAIL async_rst_en[%0d] got %b expected 0001", i, en_o[i]);
            end
            checks++;
            assert (data_o[i] === 4'h0) else begin
                errors++;
                $error("FAIL async_rst_data[%0d] got %h expected 0", i, data_o[i]);
            end
            checks++;
            assert (fd_o[i] === 1'b0) else begin
                errors++;
                $error("FAIL async_rst_fd[%0d] got %b expected 0", i, fd_o[i]);
            end
        end
        @(negedge clk);
        run(2);
        rst_n = 1'b1;
        run(20);

        // Random loads with random leading-zero depth and random spacing.
        repeat (60) begin
            logic [15:0] rv;
            rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
            step(1'b1, rv);
            run($urandom_range(0, 20));
        end
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
